// File: rtl/seg_scan_if.sv
// Load handshake between a value producer and seg_scan_ctrl.
interface seg_scan_if #(
    parameter int NUM_DIGITS = 4
) ();
    logic                    load_valid;
    logic                    load_ready;
    logic [4*NUM_DIGITS-1:0] load_data;

    modport master (output load_valid, output load_data, input load_ready);
    modport slave  (input load_valid, input load_data, output load_ready);
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller with blanking gaps and frame-boundary commit.
// Optional build macro: LEADING_ZERO_BLANK_EN (suppress leading zero digits).
module seg_scan_ctrl #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 500
) (
    input  logic                  clk,
    input  logic                  reset,
    seg_scan_if.slave             load,
    output logic [3:0]            bcd_out,
    output logic [NUM_DIGITS-1:0] digit_n,
    output logic                  frame_done
);
    localparam int MAXC = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic {BLANK, SHOW} state_t;

    state_t                         state, state_nxt;
    logic [CW-1:0]                  cnt;
    logic [IW-1:0]                  idx, idx_nxt;
    logic [NUM_DIGITS-1:0][3:0]     active, shadow, active_nxt;
    logic                           pending;
    logic                           blank_end, show_end, last, boundary, take, lit;

    function automatic logic digit_lit(input logic [NUM_DIGITS-1:0][3:0] val,
                                       input logic [IW-1:0] i);
        logic on;
`ifdef LEADING_ZERO_BLANK_EN
        logic upper_zero;
`endif
        on = (val[i] <= 4'd9);
`ifdef LEADING_ZERO_BLANK_EN
        upper_zero = 1'b1;
        for (int j = 0; j < NUM_DIGITS; j++)
            if (j >= int'(i) && val[j] != 4'd0) upper_zero = 1'b0;
        if (i != '0 && upper_zero) on = 1'b0;
`endif
        return on;
    endfunction

    always_comb begin
        blank_end  = (state == BLANK) && (cnt == CW'(BLANK_CYC - 1));
        show_end   = (state == SHOW)  && (cnt == CW'(REFRESH_DIV - 1));
        last       = (idx == IW'(NUM_DIGITS - 1));
        boundary   = show_end && last;
        take       = load.load_valid && load.load_ready;
        state_nxt  = state;
        idx_nxt    = idx;
        if (blank_end) state_nxt = SHOW;
        if (show_end) begin
            state_nxt = BLANK;
            idx_nxt   = last ? '0 : idx + 1'b1;
        end
        // Commit only at the frame edge so a frame never mixes old and new digits.
        active_nxt = (boundary && pending) ? shadow : active;
        lit        = (state_nxt == SHOW) && digit_lit(active_nxt, idx_nxt);
    end

    // Outputs are registered from next-state values so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= BLANK;
            idx             <= '0;
            cnt             <= '0;
            active          <= '0;
            shadow          <= '0;
            pending         <= 1'b0;
            load.load_ready <= 1'b1;
            digit_n         <= '1;
            bcd_out         <= 4'd0;
            frame_done      <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            cnt        <= (state_nxt != state) ? '0 : cnt + 1'b1;
            active     <= active_nxt;
            frame_done <= boundary;
            if (take) begin
                shadow          <= load.load_data;
                pending         <= 1'b1;
                load.load_ready <= 1'b0;
            end else if (boundary && pending) begin
                pending         <= 1'b0;
                load.load_ready <= 1'b1;
            end
            bcd_out <= active_nxt[idx_nxt];
            digit_n <= ~(lit ? (NUM_DIGITS'(1) << idx_nxt) : NUM_DIGITS'(0));
        end
    end
endmodule
